// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, free-running oversample tick,
// mid-bit sampling, one-cycle strobes for a good byte or a framing error.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          sync1;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [SW-1:0] s_cnt;
  logic [2:0]    b_cnt;
  logic [7:0]    shift;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      div_cnt   <= '0;
      state     <= IDLE;
      s_cnt     <= '0;
      b_cnt     <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= rx;
      rx_s      <= sync1;
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              s_cnt   <= '0;
              state   <= START;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            if (s_cnt == S_MID) begin
              if (!rx_s) begin
                s_cnt <= '0;
                b_cnt <= '0;
                state <= DATA;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          DATA: begin
            if (s_cnt == S_LAST) begin
              shift <= {rx_s, shift[7:1]};
              s_cnt <= '0;
              if (b_cnt == 3'd7) state <= STOP;
              else               b_cnt <= b_cnt + 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          STOP: begin
            // Returning to IDLE at mid stop bit lets a directly following start bit be caught.
            if (s_cnt == S_LAST) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (rx_s) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the whole line waveform is planned up front, a
// reference model derives the expected strobes, busy and data, then it is replayed.
module tb_uart_rx;

  localparam int DIV = 10;
  localparam int OS  = 16;
  localparam int BIT = DIV * OS;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  bit         line_q[$];
  bit         rst_q[$];
  bit         tick_a[];
  bit         rxs_a[];
  bit         busy_a[];
  logic [7:0] data_a[];
  int         tki[];
  int         tk[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = -1;
  bit         done = 1'b0;

  task automatic put(bit lvl, bit r, int n);
    repeat (n) begin
      line_q.push_back(lvl);
      rst_q.push_back(r);
    end
  endtask

  task automatic frame(logic [7:0] d, bit stop);
    put(1'b0, 1'b0, BIT);
    for (int k = 0; k < 8; k++) put(d[k], 1'b0, BIT);
    put(stop, 1'b0, BIT);
  endtask

  function automatic int first_rst(int a, int b);
    for (int x = a + 1; x <= b; x++) if (rst_q[x]) return x;
    return -1;
  endfunction

  // Frame timing in ticks from start detection: mid start +8, data bit k at
  // +8+16*(k+1), mid stop at +152; receiver re-arms on the tick after.
  task automatic build_model();
    int         n;
    int         cnt;
    bit         s1;
    bit         s2;
    int         c;
    logic [7:0] cur;
    ev_t        vq[$];
    n = line_q.size();
    cnt = 0; s1 = 1'b1; s2 = 1'b1;
    tick_a = new[n]; rxs_a = new[n]; busy_a = new[n]; data_a = new[n]; tki = new[n];
    for (int x = 0; x < n; x++) begin
      rxs_a[x]  = s2;
      busy_a[x] = 1'b0;
      if (rst_q[x]) begin
        tick_a[x] = 1'b0; cnt = 0; s1 = 1'b1; s2 = 1'b1;
      end else begin
        tick_a[x] = (cnt == DIV - 1);
        cnt = tick_a[x] ? 0 : cnt + 1;
        s2 = s1;
        s1 = line_q[x];
      end
      tki[x] = tk.size();
      if (tick_a[x]) tk.push_back(x);
    end
    c = 0;
    while (c < n) begin
      int t0, i, mid, stop, r, endc;
      logic [7:0] d;
      ev_t e;
      if (!tick_a[c] || rxs_a[c]) begin c++; continue; end
      t0 = c; i = tki[t0];
      if (i + 152 >= tk.size()) break;
      mid = tk[i + 8];
      stop = tk[i + 152];
      r = first_rst(t0, mid);
      if (r < 0 && rxs_a[mid]) begin
        endc = mid;
      end else begin
        if (r < 0) r = first_rst(t0, stop);
        endc = (r >= 0) ? r : stop;
        if (r < 0) begin
          for (int k = 0; k < 8; k++) d[k] = rxs_a[tk[i + 24 + 16 * k]];
          e.is_err = !rxs_a[stop]; e.data = d; e.cyc = stop;
          exp_q.push_back(e);
          if (!e.is_err) vq.push_back(e);
        end
      end
      for (int x = t0; x < endc; x++) busy_a[x] = 1'b1;
      c = (r >= 0) ? r : endc + 1;
    end
    cur = 8'h00;
    for (int x = 0; x < n; x++) begin
      if (rst_q[x]) cur = 8'h00;
      if (vq.size() > 0 && vq[0].cyc == x) begin
        cur = vq[0].data;
        void'(vq.pop_front());
      end
      data_a[x] = cur;
    end
    foreach (exp_q[j]) if (exp_q[j].is_err) exp_q[j].data = data_a[exp_q[j].cyc];
  endtask

  initial begin
    logic [7:0] rd;
    put(1'b1, 1'b1, 4);
    put(1'b1, 1'b0, 5 * BIT);
    frame(8'hA5, 1'b1);                     put(1'b1, 1'b0, 3 * BIT);
    frame(8'h00, 1'b1); frame(8'hFF, 1'b1); put(1'b1, 1'b0, 3 * BIT);
    put(1'b0, 1'b0, 40);                    put(1'b1, 1'b0, 3 * BIT);
    frame(8'h5A, 1'b1); frame(8'h3C, 1'b0); put(1'b1, 1'b0, 3 * BIT);
    // 0x96 cut short by a reset in the middle of data bit 4
    put(1'b0, 1'b0, BIT);
    rd = 8'h96;
    for (int k = 0; k < 4; k++) put(rd[k], 1'b0, BIT);
    put(rd[4], 1'b0, BIT / 2);
    put(1'b1, 1'b1, 3);
    put(1'b1, 1'b0, 5 * BIT);
    frame(8'hC3, 1'b1);                     put(1'b1, 1'b0, 3 * BIT);
    put(1'b0, 1'b0, 35 * BIT);              put(1'b1, 1'b0, 12 * BIT);
    frame(8'h81, 1'b1);                     put(1'b1, 1'b0, 3 * BIT);
    for (int j = 0; j < 12; j++) begin
      put(1'b1, 1'b0, $urandom_range(0, 2) * BIT + $urandom_range(0, 40));
      if ($urandom_range(0, 5) == 0) begin
        put(1'b0, 1'b0, $urandom_range(1, 60));
        put(1'b1, 1'b0, 2 * BIT);
      end
      rd = 8'($urandom);
      frame(rd, $urandom_range(0, 4) != 0);
    end
    put(1'b1, 1'b0, 4 * BIT);

    build_model();

    for (int x = 0; x < line_q.size(); x++) begin
      rx = line_q[x];
      reset = rst_q[x];
      @(posedge clk);
      cyc = x;
      #1;
    end
    @(negedge clk);
    #1 done = 1'b1;
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_strobe got=none exp=%s data=%h at cyc %0d",
               e.is_err ? "frame_err" : "rx_valid", e.data, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clk) begin
    ev_t e;
    if (cyc >= 0 && !done) begin
      checks++;
      if (rx_busy !== busy_a[cyc]) begin
        errors++;
        $display("FAIL rx_busy cyc=%0d got=%b exp=%b", cyc, rx_busy, busy_a[cyc]);
      end
      checks++;
      if (rx_data !== data_a[cyc]) begin
        errors++;
        $display("FAIL rx_data cyc=%0d got=%h exp=%h", cyc, rx_data, data_a[cyc]);
      end
      if (rx_valid === 1'b1 || frame_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe cyc=%0d got valid=%b err=%b exp=none",
                   cyc, rx_valid, frame_err);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (rx_valid !== !e.is_err || frame_err !== e.is_err) begin
            errors++;
            $display("FAIL strobe_kind cyc=%0d got valid=%b err=%b exp err=%b",
                     cyc, rx_valid, frame_err, e.is_err);
          end
          checks++;
          if (rx_data !== e.data) begin
            errors++;
            $display("FAIL strobe_data cyc=%0d got=%h exp=%h", cyc, rx_data, e.data);
          end
          checks++;
          if (cyc - e.cyc > 1 || e.cyc - cyc > 1) begin
            errors++;
            $display("FAIL strobe_time got cyc=%0d exp cyc=%0d", cyc, e.cyc);
          end
        end
      end
    end
  end

endmodule
